// File: rtl/proj2_pkg.sv
// Shared definitions for the instruction sequencer: word width, HALT opcode
// and the FSM state encoding shown on the HEX display.
package proj2_pkg;

    localparam int INSTR_W = 10;
    localparam int STATE_W = 2;
    localparam logic [3:0] HALT_OP = 4'b1111;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: 4] == HALT_OP;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue; the caller only raises push when there is room
// (or a pop happens in the same cycle) and only raises pop when non-empty.
module instr_fifo
    import proj2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [INSTR_W-1:0] wdata_i,
    output logic [INSTR_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [3:0]         count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0]         count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + 4'(push_i) - 4'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == 4'(DEPTH));
    assign empty_o = (count_q == 4'd0);

endmodule

// File: rtl/instr_sequencer.sv
// Issues queued instructions to the datapath controller one at a time, with
// RUN/STEP control, HALT opcode handling and an EXEC watchdog.
module instr_sequencer
    import proj2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 15
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD,
    input  logic [INSTR_W-1:0] IN_INSTR,
    input  logic               RUN,
    input  logic               STEP,
    input  logic               ISSUE_ACK,
    input  logic               DONE,
    output logic               ISSUE_VALID,
    output logic [INSTR_W-1:0] ISSUE_INSTR,
    output logic               FULL,
    output logic               EMPTY,
    output logic [3:0]         COUNT,
    output logic [STATE_W-1:0] STATE,
    output logic               OVF,
    output logic               TMO
);

    localparam int WD_W = $clog2(TMO_CYC + 1);

    state_e             state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               ovf_q, ovf_d;
    logic               tmo_q, tmo_d;
    logic [INSTR_W-1:0] head;
    logic               go, halt_head, wd_expire;
    logic               push, pop, drop;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (IN_INSTR),
        .rdata_o (head),
        .full_o  (FULL),
        .empty_o (EMPTY),
        .count_o (COUNT)
    );

    assign go        = !EMPTY && (RUN || STEP);
    assign halt_head = is_halt(head);
    // DONE on the final watchdog cycle still counts as a normal completion.
    assign wd_expire = (state_q == ST_EXEC) && !DONE && (wd_q == WD_W'(TMO_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = halt_head ? ST_HALTED : ST_ISSUE;
            ST_ISSUE:  if (ISSUE_ACK) state_d = ST_EXEC;
            ST_EXEC:   if (DONE || wd_expire) state_d = ST_IDLE;
            ST_HALTED: if (!RUN) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ISSUE_VALID = (state_q == ST_ISSUE);
        ISSUE_INSTR = ISSUE_VALID ? head : '0;
        // A HALT word leaves the queue the moment it is recognised in IDLE.
        pop  = (ISSUE_VALID && ISSUE_ACK) || ((state_q == ST_IDLE) && go && halt_head);
        push = LOAD && (!FULL || pop);
        drop = LOAD && FULL && !pop;
    end

    always_comb begin
        wd_d  = (state_q == ST_EXEC) ? wd_q + WD_W'(1) : '0;
        ovf_d = ovf_q | drop;
        tmo_d = tmo_q | wd_expire;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_q  <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            ovf_q <= ovf_d;
            tmo_q <= tmo_d;
        end
    end

    assign STATE = state_q;
    assign OVF   = ovf_q;
    assign TMO   = tmo_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: a queue model predicts occupancy/overflow and the issue
// order; a monitor compares every handshake against the expected queue.
module tb_instr_sequencer;

    localparam int DEPTH   = 4;
    localparam int TMO_CYC = 15;

    logic       CLK = 1'b0;
    logic       RST, LOAD, RUN, STEP, ISSUE_ACK, DONE;
    logic [9:0] IN_INSTR, ISSUE_INSTR;
    logic       ISSUE_VALID, FULL, EMPTY, OVF, TMO;
    logic [3:0] COUNT;
    logic [1:0] STATE;

    int         nvec = 0, nerr = 0;
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    bit         movf = 0, chk = 0, resp_en = 0, fixed = 1, no_done = 0;

    instr_sequencer #(.DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .IN_INSTR(IN_INSTR), .RUN(RUN),
        .STEP(STEP), .ISSUE_ACK(ISSUE_ACK), .DONE(DONE),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR), .FULL(FULL),
        .EMPTY(EMPTY), .COUNT(COUNT), .STATE(STATE), .OVF(OVF), .TMO(TMO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model of the next edge, using the inputs just applied.
    task automatic model_step();
        bit pop, hpop;
        if (RST) begin
            mq.delete(); exp_q.delete(); movf = 0;
            return;
        end
        hpop = (STATE == 2'd0) && (mq.size() > 0) && (RUN || STEP) && (mq[0][9:6] == 4'hF);
        pop  = (ISSUE_VALID && ISSUE_ACK) || hpop;
        if (LOAD) begin
            if (mq.size() < DEPTH || pop) begin
                mq.push_back(IN_INSTR);
                if (IN_INSTR[9:6] != 4'hF) exp_q.push_back(IN_INSTR);
            end else movf = 1;
        end
        if (pop) void'(mq.pop_front());
    endtask

    task automatic cycle(input bit rst, input bit ld, input logic [9:0] w,
                         input bit run, input bit st, input bit ld_on_ack = 0);
        @(negedge CLK);
        if (chk) begin
            check("count", COUNT, mq.size());
            check("full",  FULL,  mq.size() == DEPTH);
            check("empty", EMPTY, mq.size() == 0);
            check("ovf",   OVF,   movf);
        end
        RST = rst; LOAD = ld; IN_INSTR = w; RUN = run; STEP = st;
        #1;
        if (ld_on_ack && ISSUE_ACK) begin LOAD = 1; IN_INSTR = w; end
        model_step();
    endtask

    task automatic wait_edge();
        @(posedge CLK); #1;
    endtask

    task automatic reset_dut();
        resp_en = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        do begin
            cycle(0, 0, 0, 1, 0);
            n++;
        end while (!(mq.size() == 0 && STATE == 2'd0 && exp_q.size() == 0) && n < 300);
        cycle(0, 0, 0, 0, 0);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, STATE, 0);
        check({name, "_empty"}, EMPTY, 1);
    endtask

    // Datapath controller stand-in: ACK after a delay, DONE after another.
    initial begin
        int acnt = 0, dcnt = 0;
        bit busy = 0, armed = 0;
        ISSUE_ACK = 0; DONE = 0;
        forever begin
            @(negedge CLK);
            ISSUE_ACK = 0; DONE = 0;
            if (!resp_en) begin
                busy = 0; armed = 0;
            end else if (busy) begin
                if (STATE != 2'd2) busy = 0;
                else if (dcnt == 0) begin DONE = !no_done; busy = no_done; end
                else dcnt--;
            end else if (ISSUE_VALID) begin
                if (!armed) begin armed = 1; acnt = fixed ? 1 : int'($urandom_range(0, 3)); end
                if (acnt == 0) begin
                    ISSUE_ACK = 1; armed = 0; busy = 1;
                    dcnt = fixed ? 2 : int'($urandom_range(0, 4));
                end else acnt--;
            end
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge CLK); #1;
            if (ISSUE_VALID && ISSUE_ACK) begin
                if (exp_q.size() == 0) check("issue_unexpected", ISSUE_INSTR, 10'h3FF);
                else begin
                    e = exp_q.pop_front();
                    check("issue_instr", ISSUE_INSTR, e);
                end
            end else if (ISSUE_VALID !== 1'b1) begin
                check("instr_zero", ISSUE_INSTR, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, execn;
        bit loaded, run, ld, st;
        logic [9:0] w;
        logic [9:0] fill [5];
        fill = '{10'h041, 10'h082, 10'h0C3, 10'h104, 10'h145};

        RST = 1; LOAD = 0; IN_INSTR = 0; RUN = 0; STEP = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        wait_edge();
        check("rst_state", STATE, 0);
        check("rst_valid", ISSUE_VALID, 0);
        check("rst_instr", ISSUE_INSTR, 0);
        check("rst_count", COUNT, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_ovf", OVF, 0);
        check("rst_tmo", TMO, 0);
        chk = 1;

        // Fill past capacity, then run the four accepted words in order.
        for (int i = 0; i < 5; i++) cycle(0, 1, fill[i], 0, 0);
        wait_edge();
        check("fill_count", COUNT, 4);
        check("fill_full", FULL, 1);
        check("fill_ovf", OVF, 1);
        fixed = 1; resp_en = 1;
        drain("run");

        // Single step, then HALT consumption and exit.
        reset_dut();
        cycle(0, 1, 10'h041, 0, 0);
        cycle(0, 1, 10'h3C0, 0, 0);
        cycle(0, 1, 10'h082, 0, 0);
        resp_en = 1;
        cycle(0, 0, 0, 0, 1);
        n = 0;
        do begin cycle(0, 0, 0, 0, 0); n++; end
        while (!(STATE == 2'd0 && exp_q.size() == 1) && n < 40);
        repeat (3) cycle(0, 0, 0, 0, 0);
        check("step_state", STATE, 0);
        check("step_count", COUNT, 2);
        check("step_pending", exp_q.size(), 1);
        repeat (3) cycle(0, 0, 0, 1, 0);
        check("halt_state", STATE, 3);
        check("halt_count", COUNT, 1);
        cycle(0, 0, 0, 0, 0);
        wait_edge();
        check("halt_exit", STATE, 0);
        drain("halt");

        // Watchdog: DONE never comes.
        reset_dut();
        cycle(0, 1, 10'h041, 0, 0);
        no_done = 1; resp_en = 1;
        cycle(0, 0, 0, 0, 1);
        execn = 0; n = 0;
        while (n < 60) begin
            cycle(0, 0, 0, 0, 0);
            n++;
            if (STATE == 2'd2) begin
                execn++;
                if (execn == TMO_CYC - 1) check("tmo_early", TMO, 0);
            end else if (execn > 0) break;
        end
        check("wd_cycles", execn, TMO_CYC);
        check("wd_tmo", TMO, 1);
        check("wd_state", STATE, 0);
        resp_en = 0; no_done = 0;

        // Push into a full queue in the ACK cycle.
        reset_dut();
        for (int i = 0; i < 4; i++) cycle(0, 1, fill[i], 0, 0);
        resp_en = 1; loaded = 0; n = 0;
        while (!loaded && n < 40) begin
            cycle(0, 0, 10'h1FF, 1, 0, 1);
            if (LOAD) loaded = 1;
            n++;
        end
        check("ack_load_seen", loaded, 1);
        wait_edge();
        check("pp_count", COUNT, 4);
        check("pp_full", FULL, 1);
        check("pp_ovf", OVF, 0);
        drain("pushpop");

        // Randomised traffic with random handshake timing.
        reset_dut();
        fixed = 0; resp_en = 1; run = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            ld = ($urandom_range(0, 2) == 0);
            w  = 10'($urandom);
            if (w[9:6] == 4'hF) w[9] = 1'b0;
            st = !run && ($urandom_range(0, 7) == 0);
            cycle(0, ld, w, run, st);
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
